// File: rtl/div_iter_if.sv
// Operand/result bundle for div_iter; master drives requests, slave returns results.
// start is accepted only while busy is low; no queuing, so masters must wait for done.
interface div_iter_if #(
  parameter int LENGTH = 32
);
  logic              start;
  logic [LENGTH-1:0] A;
  logic [LENGTH-1:0] B;
  logic [LENGTH-1:0] Q;
  logic [LENGTH-1:0] R;
  logic              done;
  logic              busy;
  logic              div_by_zero;

  modport master (
    output start, A, B,
    input  Q, R, done, busy, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output Q, R, done, busy, div_by_zero
  );
endinterface

// File: rtl/div_iter.sv
// Shift-subtract divider, LENGTH+2 cycle latency (2 for divide-by-zero/overflow), one-cycle done.
// One operation in flight: start is ignored while busy and never queued.
module div_iter #(
  parameter int LENGTH       = 32,
  parameter bit UNSIGNED_DIV = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  localparam int CW = $clog2(LENGTH);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t            state, state_nxt;
  logic [LENGTH-1:0] a_r, b_r, babs, quo;
  logic [LENGTH:0]   rem;
  logic [CW-1:0]     cnt;
  logic              sq, sr;
  logic [LENGTH-1:0] q_r, r_r;
  logic              done_r, dbz_r;

  logic              a_neg, b_neg, b_zero, ovf;
  logic [LENGTH-1:0] a_abs, b_abs;
  logic [LENGTH:0]   rem_sh;
  logic [LENGTH+1:0] trial;

  assign a_neg  = !UNSIGNED_DIV && a_r[LENGTH-1];
  assign b_neg  = !UNSIGNED_DIV && b_r[LENGTH-1];
  assign a_abs  = a_neg ? -a_r : a_r;
  assign b_abs  = b_neg ? -b_r : b_r;
  assign b_zero = (b_r == '0);
  // Most-negative / -1 has no representable quotient; it bypasses the iteration.
  assign ovf    = !UNSIGNED_DIV && (a_r == {1'b1, {(LENGTH-1){1'b0}}}) && (&b_r);

  assign rem_sh = {rem[LENGTH-1:0], quo[LENGTH-1]};
  assign trial  = {1'b0, rem_sh} - {2'b00, babs};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PREP;
      PREP:    state_nxt = (b_zero || ovf) ? FIX : CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      babs   <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      sq     <= 1'b0;
      sr     <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      dbz_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r <= bus.A;
            b_r <= bus.B;
          end
        end
        PREP: begin
          babs <= b_abs;
          quo  <= a_abs;
          rem  <= '0;
          sq   <= a_neg ^ b_neg;
          sr   <= a_neg;
          cnt  <= CW'(LENGTH - 1);
        end
        CALC: begin
          // Remainder never exceeds babs, so the shifted value fits LENGTH+1 bits.
          if (!trial[LENGTH+1]) begin
            rem <= trial[LENGTH:0];
            quo <= {quo[LENGTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[LENGTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (b_zero) begin
            q_r   <= '1;
            r_r   <= a_r;
            dbz_r <= 1'b1;
          end else if (ovf) begin
            q_r   <= a_r;
            r_r   <= '0;
            dbz_r <= 1'b0;
          end else begin
            q_r   <= sq ? -quo : quo;
            r_r   <= sr ? -rem[LENGTH-1:0] : rem[LENGTH-1:0];
            dbz_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Q           = q_r;
  assign bus.R           = r_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench: one unsigned and one signed divider share the same stimulus.
module tb_div_iter;

  localparam int L = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [L-1:0]  a, b;

  int n_vec = 0;
  int n_err = 0;
  int lat_u, lat_s, busy_u, busy_s;

  div_iter_if #(.LENGTH(L)) u_if ();
  div_iter_if #(.LENGTH(L)) s_if ();

  assign u_if.start = start;
  assign u_if.A     = a;
  assign u_if.B     = b;
  assign s_if.start = start;
  assign s_if.A     = a;
  assign s_if.B     = b;

  div_iter #(.LENGTH(L), .UNSIGNED_DIV(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
  div_iter #(.LENGTH(L), .UNSIGNED_DIV(1'b0)) s_dut (.clk(clk), .rst(rst), .bus(s_if.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start (immediately if b2b, else at the next cycle) and time both done pulses.
  // A nonzero rp re-pulses start with other operands rp edges into the operation.
  task automatic run(input logic [L-1:0] av, input logic [L-1:0] bv,
                     input int rp, input bit b2b);
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start  = 1'b0;
    lat_u  = -1;
    lat_s  = -1;
    busy_u = int'(u_if.busy);
    busy_s = int'(s_if.busy);
    for (int n = 1; n <= 40; n++) begin
      if (rp != 0 && n == rp) begin
        start = 1'b1;
        a     = 32'd77;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      busy_u += int'(u_if.busy);
      busy_s += int'(s_if.busy);
      if (u_if.done && lat_u < 0) lat_u = n;
      if (s_if.done && lat_s < 0) lat_s = n;
      if (lat_u >= 0 && lat_s >= 0) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int done_seen;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_q",    u_if.Q, 0);
    check("rst_r",    u_if.R, 0);
    check("rst_done", {u_if.done, s_if.done}, 0);
    check("rst_busy", {u_if.busy, s_if.busy}, 0);
    check("rst_dbz",  {u_if.div_by_zero, s_if.div_by_zero}, 0);

    run(32'd100, 32'd7, 0, 1'b0);
    check("u100_lat",  lat_u, 34);
    check("u100_busy", busy_u, 34);
    check("u100_q",    u_if.Q, 14);
    check("u100_r",    u_if.R, 2);
    check("u100_dbz",  u_if.div_by_zero, 0);
    check("s100_q",    s_if.Q, 14);

    run(32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    check("sm7_q", s_if.Q, 32'hFFFF_FFFD);
    check("sm7_r", s_if.R, 32'hFFFF_FFFF);
    check("um7_q", u_if.Q, 32'h7FFF_FFFC);
    check("um7_r", u_if.R, 1);

    run(32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    check("s7m2_q", s_if.Q, 32'hFFFF_FFFD);
    check("s7m2_r", s_if.R, 1);
    check("u7m2_q", u_if.Q, 0);
    check("u7m2_r", u_if.R, 7);

    run(32'h0000_1234, 32'd0, 0, 1'b0);
    check("dz_lat_u", lat_u, 2);
    check("dz_lat_s", lat_s, 2);
    check("dz_q",     u_if.Q, 32'hFFFF_FFFF);
    check("dz_r",     u_if.R, 32'h0000_1234);
    check("dz_flag",  {u_if.div_by_zero, s_if.div_by_zero}, 2'b11);
    check("dz_s_q",   s_if.Q, 32'hFFFF_FFFF);

    run(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    check("max_q",    u_if.Q, 32'hFFFF_FFFF);
    check("max_r",    u_if.R, 0);
    check("max_dbz",  {u_if.div_by_zero, s_if.div_by_zero}, 0);
    check("sm1_q",    s_if.Q, 32'hFFFF_FFFF);

    run(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("ovf_lat_s", lat_s, 2);
    check("ovf_q",     s_if.Q, 32'h8000_0000);
    check("ovf_r",     s_if.R, 0);
    check("ovf_dbz",   s_if.div_by_zero, 0);
    check("uovf_lat",  lat_u, 34);
    check("uovf_q",    u_if.Q, 0);
    check("uovf_r",    u_if.R, 32'h8000_0000);

    run(32'd5, 32'd9, 0, 1'b0);
    check("u5_9_q", u_if.Q, 0);
    check("u5_9_r", u_if.R, 5);
    check("s5_9_r", s_if.R, 5);

    run(32'd1000, 32'd10, 12, 1'b0);
    check("rep_lat", lat_u, 34);
    check("rep_q",   u_if.Q, 100);
    check("rep_r",   u_if.R, 0);

    run(32'd100, 32'd7, 0, 1'b0);
    run(32'd200, 32'd9, 0, 1'b1);
    check("b2b_lat", lat_u, 34);
    check("b2b_q",   u_if.Q, 22);
    check("b2b_r",   u_if.R, 2);

    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'd1000;
    b     = 32'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_q",    u_if.Q, 0);
    check("mrst_r",    u_if.R, 0);
    check("mrst_busy", {u_if.busy, s_if.busy}, 0);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      done_seen += int'(u_if.done) + int'(s_if.done);
    end
    check("mrst_nodone", done_seen, 0);

    run(32'd1000, 32'd10, 0, 1'b0);
    check("post_lat", lat_u, 34);
    check("post_q",   u_if.Q, 100);
    check("post_r",   s_if.R, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
